// File: rtl/mem_burst_pkg.sv
// Shared FSM state encoding and default widths for the burst arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_t;

    localparam int DEF_CH_NUM        = 4;
    localparam int DEF_ADDR_BITS     = 28;
    localparam int DEF_MEM_DATA_BITS = 128;
    localparam int DEF_LEN_BITS      = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [N-1:0] rot;
    int           sel;

    always_comb begin
        // rot[i] is the request of channel (ptr + i) mod N
        rot     = N'({req, req} >> ptr);
        sel     = 0;
        gnt_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel     = i;
                gnt_vld = 1'b1;
            end
        end
        sel = sel + int'(ptr);
        if (sel >= N) begin
            sel = sel - N;
        end
        gnt_idx = IW'(sel);
        for (int k = 0; k < N; k++) begin
            gnt[k] = gnt_vld && (sel == k);
        end
    end

endmodule

// File: rtl/mem_burst_arb.sv
// Shares one downstream burst port among CH_NUM clients, one burst at a time, round-robin.
// Latency: downstream req one cycle after a request is sampled in IDLE; data/finish routed combinationally.
// Backpressure: clients hold req until finish; MEM_BURST_ARB_WR_FIRST_EN gives writes priority.
module mem_burst_arb
    import mem_burst_pkg::*;
#(
    parameter int CH_NUM        = DEF_CH_NUM,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int MEM_DATA_BITS = DEF_MEM_DATA_BITS,
    parameter int LEN_BITS      = DEF_LEN_BITS
) (
    input  logic                              mem_clk,
    input  logic                              rst,

    input  logic [CH_NUM-1:0]                 ch_rd_burst_req,
    input  logic [CH_NUM-1:0]                 ch_wr_burst_req,
    input  logic [CH_NUM*LEN_BITS-1:0]        ch_rd_burst_len,
    input  logic [CH_NUM*LEN_BITS-1:0]        ch_wr_burst_len,
    input  logic [CH_NUM*ADDR_BITS-1:0]       ch_rd_burst_addr,
    input  logic [CH_NUM*ADDR_BITS-1:0]       ch_wr_burst_addr,
    input  logic [CH_NUM*MEM_DATA_BITS-1:0]   ch_wr_burst_data,
    output logic [CH_NUM-1:0]                 ch_wr_burst_data_req,
    output logic [CH_NUM-1:0]                 ch_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0]          ch_rd_burst_data,
    output logic [CH_NUM-1:0]                 ch_rd_burst_finish,
    output logic [CH_NUM-1:0]                 ch_wr_burst_finish,

    output logic                              rd_burst_req,
    output logic                              wr_burst_req,
    output logic [LEN_BITS-1:0]               rd_burst_len,
    output logic [LEN_BITS-1:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]              rd_burst_addr,
    output logic [ADDR_BITS-1:0]              wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]          wr_burst_data,
    input  logic                              rd_burst_data_valid,
    input  logic                              wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0]          rd_burst_data,
    input  logic                              rd_burst_finish,
    input  logic                              wr_burst_finish,

    output logic [$clog2(CH_NUM)-1:0]         grant_ch,
    output logic                              grant_busy
);

    localparam int GW = $clog2(CH_NUM);

    arb_state_t               state;
    logic [GW-1:0]            rr_ptr;
    logic [CH_NUM-1:0]        arb_req;
    logic [CH_NUM-1:0]        win_gnt;
    logic [GW-1:0]            win_idx;
    logic                     win_vld;
    logic                     win_rd;
    logic [LEN_BITS-1:0]      sel_rd_len;
    logic [LEN_BITS-1:0]      sel_wr_len;
    logic [ADDR_BITS-1:0]     sel_rd_addr;
    logic [ADDR_BITS-1:0]     sel_wr_addr;

`ifdef MEM_BURST_ARB_WR_FIRST_EN
    // Any pending write shuts reads out of this arbitration round entirely.
    always_comb begin
        arb_req = (|ch_wr_burst_req) ? ch_wr_burst_req : ch_rd_burst_req;
        win_rd  = ~(|ch_wr_burst_req);
    end
`else
    always_comb begin
        arb_req = ch_rd_burst_req | ch_wr_burst_req;
        win_rd  = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (win_gnt[k]) begin
                win_rd = ch_rd_burst_req[k];
            end
        end
    end
`endif

    rr_arbiter #(
        .N  (CH_NUM),
        .IW (GW)
    ) u_rr_arbiter (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt     (win_gnt),
        .gnt_idx (win_idx),
        .gnt_vld (win_vld)
    );

    always_comb begin
        sel_rd_len  = '0;
        sel_wr_len  = '0;
        sel_rd_addr = '0;
        sel_wr_addr = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (win_gnt[k]) begin
                sel_rd_len  = ch_rd_burst_len[k*LEN_BITS +: LEN_BITS];
                sel_wr_len  = ch_wr_burst_len[k*LEN_BITS +: LEN_BITS];
                sel_rd_addr = ch_rd_burst_addr[k*ADDR_BITS +: ADDR_BITS];
                sel_wr_addr = ch_wr_burst_addr[k*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant_ch      <= '0;
            grant_busy    <= 1'b0;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            wr_burst_len  <= '0;
            rd_burst_addr <= '0;
            wr_burst_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        grant_ch   <= win_idx;
                        grant_busy <= 1'b1;
                        rr_ptr     <= (win_idx == GW'(CH_NUM - 1)) ? '0 : win_idx + 1'b1;
                        if (win_rd) begin
                            state         <= ST_RD;
                            rd_burst_req  <= 1'b1;
                            rd_burst_len  <= sel_rd_len;
                            rd_burst_addr <= sel_rd_addr;
                        end else begin
                            state         <= ST_WR;
                            wr_burst_req  <= 1'b1;
                            wr_burst_len  <= sel_wr_len;
                            wr_burst_addr <= sel_wr_addr;
                        end
                    end
                end
                ST_RD: begin
                    if (rd_burst_finish) begin
                        state        <= ST_IDLE;
                        rd_burst_req <= 1'b0;
                        grant_busy   <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (wr_burst_finish) begin
                        state        <= ST_IDLE;
                        wr_burst_req <= 1'b0;
                        grant_busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Returns reach only the owner, and only for the direction in flight.
    always_comb begin
        ch_rd_burst_data_valid = '0;
        ch_wr_burst_data_req   = '0;
        ch_rd_burst_finish     = '0;
        ch_wr_burst_finish     = '0;
        wr_burst_data          = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (int'(grant_ch) == k) begin
                ch_rd_burst_data_valid[k] = (state == ST_RD) && rd_burst_data_valid;
                ch_rd_burst_finish[k]     = (state == ST_RD) && rd_burst_finish;
                ch_wr_burst_data_req[k]   = (state == ST_WR) && wr_burst_data_req;
                ch_wr_burst_finish[k]     = (state == ST_WR) && wr_burst_finish;
                if (state == ST_WR) begin
                    wr_burst_data = ch_wr_burst_data[k*MEM_DATA_BITS +: MEM_DATA_BITS];
                end
            end
        end
    end

    assign ch_rd_burst_data = rd_burst_data;

endmodule

// File: tb/tb_mem_burst_arb.sv
// Directed bench for mem_burst_arb: single write, round-robin reads, rd/wr ordering, reset mid-burst,
// client drop mid-burst and spurious finishes.
module tb_mem_burst_arb;

    localparam int CH = 4;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int LW = 10;

    logic                 mem_clk;
    logic                 rst;
    logic [CH-1:0]        ch_rd_burst_req;
    logic [CH-1:0]        ch_wr_burst_req;
    logic [CH*LW-1:0]     ch_rd_burst_len;
    logic [CH*LW-1:0]     ch_wr_burst_len;
    logic [CH*AW-1:0]     ch_rd_burst_addr;
    logic [CH*AW-1:0]     ch_wr_burst_addr;
    logic [CH*DW-1:0]     ch_wr_burst_data;
    logic [CH-1:0]        ch_wr_burst_data_req;
    logic [CH-1:0]        ch_rd_burst_data_valid;
    logic [DW-1:0]        ch_rd_burst_data;
    logic [CH-1:0]        ch_rd_burst_finish;
    logic [CH-1:0]        ch_wr_burst_finish;
    logic                 rd_burst_req;
    logic                 wr_burst_req;
    logic [LW-1:0]        rd_burst_len;
    logic [LW-1:0]        wr_burst_len;
    logic [AW-1:0]        rd_burst_addr;
    logic [AW-1:0]        wr_burst_addr;
    logic [DW-1:0]        wr_burst_data;
    logic                 rd_burst_data_valid;
    logic                 wr_burst_data_req;
    logic [DW-1:0]        rd_burst_data;
    logic                 rd_burst_finish;
    logic                 wr_burst_finish;
    logic [1:0]           grant_ch;
    logic                 grant_busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_burst_arb #(
        .CH_NUM        (CH),
        .ADDR_BITS     (AW),
        .MEM_DATA_BITS (DW),
        .LEN_BITS      (LW)
    ) dut (
        .mem_clk                (mem_clk),
        .rst                    (rst),
        .ch_rd_burst_req        (ch_rd_burst_req),
        .ch_wr_burst_req        (ch_wr_burst_req),
        .ch_rd_burst_len        (ch_rd_burst_len),
        .ch_wr_burst_len        (ch_wr_burst_len),
        .ch_rd_burst_addr       (ch_rd_burst_addr),
        .ch_wr_burst_addr       (ch_wr_burst_addr),
        .ch_wr_burst_data       (ch_wr_burst_data),
        .ch_wr_burst_data_req   (ch_wr_burst_data_req),
        .ch_rd_burst_data_valid (ch_rd_burst_data_valid),
        .ch_rd_burst_data       (ch_rd_burst_data),
        .ch_rd_burst_finish     (ch_rd_burst_finish),
        .ch_wr_burst_finish     (ch_wr_burst_finish),
        .rd_burst_req           (rd_burst_req),
        .wr_burst_req           (wr_burst_req),
        .rd_burst_len           (rd_burst_len),
        .wr_burst_len           (wr_burst_len),
        .rd_burst_addr          (rd_burst_addr),
        .wr_burst_addr          (wr_burst_addr),
        .wr_burst_data          (wr_burst_data),
        .rd_burst_data_valid    (rd_burst_data_valid),
        .wr_burst_data_req      (wr_burst_data_req),
        .rd_burst_data          (rd_burst_data),
        .rd_burst_finish        (rd_burst_finish),
        .wr_burst_finish        (wr_burst_finish),
        .grant_ch               (grant_ch),
        .grant_busy             (grant_busy)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] wdat(input int ch);
        return {4{32'hA5A5_0000 | 32'(ch)}};
    endfunction

    // Entered one step after the grant edge; leaves inside the following IDLE cycle.
    task automatic rd_burst(input int ch, input int beats, input logic [AW-1:0] exp_addr,
                            input logic [LW-1:0] exp_len);
        logic [DW-1:0] d;
        chk("rd_req", DW'(rd_burst_req), DW'(1));
        chk("rd_wr_idle", DW'(wr_burst_req), DW'(0));
        chk("rd_grant_ch", DW'(grant_ch), DW'(ch));
        chk("rd_busy", DW'(grant_busy), DW'(1));
        chk("rd_addr", DW'(rd_burst_addr), DW'(exp_addr));
        chk("rd_len", DW'(rd_burst_len), DW'(exp_len));
        for (int i = 0; i < beats; i++) begin
            d = {4{32'hC0DE_0000 + 32'(ch * 16 + i)}};
            rd_burst_data       = d;
            rd_burst_data_valid = 1'b1;
            #1;
            chk("rd_dv", DW'(ch_rd_burst_data_valid), DW'(32'(1) << ch));
            chk("rd_dat", ch_rd_burst_data, d);
            chk("rd_hold", DW'(rd_burst_req), DW'(1));
            tick();
        end
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = 1'b1;
        #1;
        chk("rd_fin", DW'(ch_rd_burst_finish), DW'(32'(1) << ch));
        chk("rd_fin_wr", DW'(ch_wr_burst_finish), DW'(0));
        tick();
        rd_burst_finish = 1'b0;
        #1;
        chk("rd_req_drop", DW'(rd_burst_req), DW'(0));
        chk("rd_idle_gap", DW'(grant_busy), DW'(0));
    endtask

    task automatic wr_burst(input int ch, input int beats, input logic [AW-1:0] exp_addr,
                            input logic [LW-1:0] exp_len);
        chk("wr_req", DW'(wr_burst_req), DW'(1));
        chk("wr_rd_idle", DW'(rd_burst_req), DW'(0));
        chk("wr_grant_ch", DW'(grant_ch), DW'(ch));
        chk("wr_addr", DW'(wr_burst_addr), DW'(exp_addr));
        chk("wr_len", DW'(wr_burst_len), DW'(exp_len));
        for (int i = 0; i < beats; i++) begin
            wr_burst_data_req = 1'b1;
            rd_burst_finish   = (i == 1);
            #1;
            chk("wr_dreq", DW'(ch_wr_burst_data_req), DW'(32'(1) << ch));
            chk("wr_dat", wr_burst_data, wdat(ch));
            chk("wr_hold", DW'(wr_burst_req), DW'(1));
            if (i == 1) begin
                chk("wr_wrong_dir_fin", DW'(ch_rd_burst_finish), DW'(0));
            end
            tick();
        end
        wr_burst_data_req = 1'b0;
        rd_burst_finish   = 1'b0;
        wr_burst_finish   = 1'b1;
        #1;
        chk("wr_fin", DW'(ch_wr_burst_finish), DW'(32'(1) << ch));
        chk("wr_fin_rd", DW'(ch_rd_burst_finish), DW'(0));
        tick();
        wr_burst_finish = 1'b0;
        #1;
        chk("wr_req_drop", DW'(wr_burst_req), DW'(0));
        chk("wr_idle_gap", DW'(grant_busy), DW'(0));
    endtask

    initial begin
        rst                 = 1'b1;
        ch_rd_burst_req     = '0;
        ch_wr_burst_req     = '0;
        rd_burst_data_valid = 1'b0;
        wr_burst_data_req   = 1'b0;
        rd_burst_data       = '0;
        rd_burst_finish     = 1'b0;
        wr_burst_finish     = 1'b0;
        for (int k = 0; k < CH; k++) begin
            ch_rd_burst_addr[k*AW +: AW] = AW'(32'h1000 * (k + 1));
            ch_rd_burst_len[k*LW +: LW]  = LW'(k + 2);
            ch_wr_burst_addr[k*AW +: AW] = AW'(32'h2000 * (k + 1));
            ch_wr_burst_len[k*LW +: LW]  = LW'(k + 3);
            ch_wr_burst_data[k*DW +: DW] = wdat(k);
        end
        ch_wr_burst_addr[1*AW +: AW] = AW'(32'h100);
        ch_wr_burst_len[1*LW +: LW]  = LW'(16);

        repeat (2) tick();
        chk("rst_busy", DW'(grant_busy), DW'(0));
        chk("rst_grant_ch", DW'(grant_ch), DW'(0));
        chk("rst_rd_req", DW'(rd_burst_req), DW'(0));
        chk("rst_wr_req", DW'(wr_burst_req), DW'(0));
        chk("rst_wr_data", wr_burst_data, DW'(0));
        rst = 1'b0;
        tick();

        // Single write on ch1: 16 beats at 0x100
        ch_wr_burst_req[1] = 1'b1;
        #1;
        chk("wr_req_before_edge", DW'(wr_burst_req), DW'(0));
        tick();
        wr_burst(1, 16, AW'(32'h100), LW'(16));
        ch_wr_burst_req[1] = 1'b0;

        // Spurious downstream finishes while idle
        rd_burst_finish = 1'b1;
        wr_burst_finish = 1'b1;
        #1;
        chk("idle_rd_fin", DW'(ch_rd_burst_finish), DW'(0));
        chk("idle_wr_fin", DW'(ch_wr_burst_finish), DW'(0));
        tick();
        rd_burst_finish = 1'b0;
        wr_burst_finish = 1'b0;
        #1;
        chk("idle_stay_busy", DW'(grant_busy), DW'(0));
        chk("idle_stay_rd", DW'(rd_burst_req), DW'(0));
        chk("idle_stay_wr", DW'(wr_burst_req), DW'(0));

        // Reset at the fifth read beat of a ch2 burst
        ch_rd_burst_req[2] = 1'b1;
        tick();
        chk("rr_after_ch1", DW'(grant_ch), DW'(2));
        chk("rr_rd_req", DW'(rd_burst_req), DW'(1));
        for (int i = 0; i < 4; i++) begin
            rd_burst_data_valid = 1'b1;
            #1;
            chk("pre_rst_dv", DW'(ch_rd_burst_data_valid), DW'(4'b0100));
            tick();
        end
        rst             = 1'b1;
        ch_rd_burst_req = 4'b1111;
        tick();
        rd_burst_finish = 1'b1;
        #1;
        chk("mid_rst_rd_req", DW'(rd_burst_req), DW'(0));
        chk("mid_rst_busy", DW'(grant_busy), DW'(0));
        chk("mid_rst_grant_ch", DW'(grant_ch), DW'(0));
        chk("mid_rst_addr", DW'(rd_burst_addr), DW'(0));
        chk("mid_rst_len", DW'(rd_burst_len), DW'(0));
        chk("mid_rst_fin", DW'(ch_rd_burst_finish), DW'(0));
        chk("mid_rst_dv", DW'(ch_rd_burst_data_valid), DW'(0));
        rst                 = 1'b0;
        rd_burst_finish     = 1'b0;
        rd_burst_data_valid = 1'b0;

        // All channels reading continuously: 0,1,2,3,0
        for (int b = 0; b < 5; b++) begin
            tick();
            rd_burst(b % 4, 2, AW'(32'h1000 * ((b % 4) + 1)), LW'((b % 4) + 2));
        end
        ch_rd_burst_req = '0;

        // Ch2 with read and write both pending
        ch_rd_burst_req[2] = 1'b1;
        ch_wr_burst_req[2] = 1'b1;
        tick();
`ifdef MEM_BURST_ARB_WR_FIRST_EN
        wr_burst(2, 3, AW'(32'h6000), LW'(5));
        ch_wr_burst_req[2] = 1'b0;
        tick();
        rd_burst(2, 2, AW'(32'h3000), LW'(4));
        ch_rd_burst_req[2] = 1'b0;
`else
        rd_burst(2, 2, AW'(32'h3000), LW'(4));
        ch_rd_burst_req[2] = 1'b0;
        tick();
        wr_burst(2, 3, AW'(32'h6000), LW'(5));
        ch_wr_burst_req[2] = 1'b0;
`endif

        // Ch3 drops its request right after the grant; burst still completes
        ch_rd_burst_req[3] = 1'b1;
        tick();
        ch_rd_burst_req[3] = 1'b0;
        rd_burst(3, 3, AW'(32'h4000), LW'(5));

        tick();
        chk("end_idle", DW'(grant_busy), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
